mult_seq: RTL and testbench
===========================

MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 Parameter W, default 8: operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with operands.
REQ-006 a  input  W  multiplicand, captured on accepted start.
REQ-007 b  input  W  multiplier, captured on accepted start.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle pulse marking out valid for the new result.
REQ-010 out  output  2W  product; holds last result until the next done.

Function
REQ-011 FSM SHALL have states IDLE, CALC, DONE.
REQ-012 IDLE with start=1 at an edge SHALL capture a, b, signed_mode and go to CALC; IDLE with start=0 SHALL stay in IDLE.
REQ-013 CALC SHALL run exactly W iterations, one per clock, of shift-add on operand magnitudes (LSB-first multiplier); then go to DONE.
REQ-014 DONE SHALL last one cycle with done=1 and out=final product, then return to IDLE.
REQ-015 Latency: done SHALL be high in the cycle after the (W+1)th rising edge counted from the start-accepting edge; fixed, independent of operand values (zero operands included).
REQ-016 start while busy=1 SHALL be ignored, with no effect on the operation in flight; start in the IDLE cycle following DONE SHALL be accepted.
REQ-017 Unsigned mode: out SHALL equal a*b, exact, zero-extended to 2W bits.
REQ-018 Signed mode: magnitudes SHALL be formed at capture; result sign = a[W-1] XOR b[W-1]; negated in 2W-bit two's complement at DONE if the sign is negative.
REQ-019 Signed -2^(W-1) operand: magnitude 2^(W-1) SHALL be represented without overflow; (-2^(W-1))^2 SHALL give +2^(2W-2).
REQ-020 A negative-sign result with zero magnitude SHALL yield out=0.
REQ-021 out SHALL change only on the DONE transition or on reset; input changes after capture SHALL not affect the result.
REQ-022 Iteration counter width SHALL be clog2(W+1); no wrap-around within one operation.

Reset
REQ-023 rst_n=0 at a rising edge SHALL force state=IDLE, busy=0, done=0, out=0, and clear the accumulator, operand and counter registers.
REQ-024 Reset during CALC or DONE SHALL abort the operation; no done SHALL follow.
REQ-025 Reset SHALL take priority over start in the same cycle.

Structure
REQ-026 State encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the default W SHALL live in shared package mult_pkg.
REQ-027 The datapath (magnitude, shift-add accumulator, final negate) SHALL be sub-module mult_seq_dp; the FSM and counter SHALL stay in mult_seq.
REQ-028 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification
REQ-029 W=8, unsigned, a=0x25, b=0x0F, start pulse -> done 9 edges later, out=0x022B, busy high throughout.
REQ-030 W=8, unsigned, a=0xFF, b=0xFF -> out=0xFE01; signed, a=0xFD (-3), b=0x05 -> out=0xFFF1.
REQ-031 W=8, signed, a=0x80, b=0x80 -> out=0x4000; signed, a=0x80, b=0x01 -> out=0xFF80.
REQ-032 start held high for 20 cycles with a=3, b=4 -> results 0x000C issued back-to-back every 10 cycles; operand changes during CALC do not alter out.
REQ-033 rst_n pulled low for one cycle mid-CALC -> next cycle busy=0, out=0, no done; a following start with a=2, b=3 -> out=0x0006.
REQ-034 W=16 instance, unsigned, a=0xFFFF, b=0xFFFF -> out=0xFFFE0001, done 17 edges after start.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding,
// default operand width and the iteration-counter sizing helper.
package mult_pkg;

  localparam int DEFAULT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold the value W without wrapping.
  function automatic int iter_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mult_seq_dp.sv
// Datapath of the sequential multiplier: operand magnitude capture, LSB-first
// shift-add accumulation and the final two's-complement fix-up of the product.
module mult_seq_dp
  import mult_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic           finish,
  input  logic           signed_mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] out
);

  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_next;
  logic [W-1:0]   mplier;
  logic           neg;
  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;

  // An unsigned W-bit magnitude holds 2^(W-1), so the most negative operand is safe.
  always_comb begin
    mag_a = a;
    mag_b = b;
    if (signed_mode && a[W-1]) mag_a = ~a + W'(1);
    if (signed_mode && b[W-1]) mag_b = ~b + W'(1);
  end

  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      out    <= '0;
    end else if (load) begin
      mcand  <= {{W{1'b0}}, mag_a};
      mplier <= mag_b;
      acc    <= '0;
      neg    <= signed_mode & (a[W-1] ^ b[W-1]);
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      // Negating a zero magnitude yields zero, so no special case is needed.
      if (finish) out <= neg ? -acc_next : acc_next;
    end
  end

endmodule

// File: rtl/mult_seq.sv
// Sequential W x W multiplier: IDLE/CALC/DONE control with an iteration counter,
// driving the mult_seq_dp datapath; busy and done are registered.
module mult_seq
  import mult_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] out
);

  localparam int CW = iter_cnt_w(W);

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic          last;
  logic          load;
  logic          step;
  logic          finish;

  assign last = (cnt == CW'(W - 1));

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) begin
          finish     = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // busy/done are computed from next_state so they are true flops aligned with state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      done  <= (next_state == DONE);
      if (load)      cnt <= '0;
      else if (step) cnt <= cnt + CW'(1);
    end
  end

  mult_seq_dp #(.W(W)) u_dp (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .step        (step),
    .finish      (finish),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .out         (out)
  );

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: W=8 and W=16 instances against a
// timeline/arithmetic reference model, plus literal directed cases.
module tb_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] out8;
  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16;
  logic [31:0] out16;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_seq #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .out(out8)
  );

  mult_seq #(.W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .out(out16)
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Mathematical product of the operands, reduced modulo 2^(2w).
  function automatic longint expected_product(input int w, input bit sm, input longint av, input longint bv);
    longint sa, sb, p;
    sa = av;
    sb = bv;
    if (sm && av >= (longint'(1) << (w - 1))) sa = av - (longint'(1) << w);
    if (sm && bv >= (longint'(1) << (w - 1))) sb = bv - (longint'(1) << w);
    p = sa * sb;
    return p & ((longint'(1) << (2 * w)) - 1);
  endfunction

  // Model: an accepted op at edge t shows done after edge t+W and frees the unit after edge t+W+1.
  bit     m8_fl, m8_done, m8_busy;
  int     m8_acc;
  longint m8_pend, m8_out;
  bit     m16_fl, m16_done, m16_busy;
  int     m16_acc;
  longint m16_pend, m16_out;

  always @(posedge clk) begin
    if (!rst_n) begin
      m8_fl = 0; m8_done = 0; m8_busy = 0; m8_out = 0;
      m16_fl = 0; m16_done = 0; m16_busy = 0; m16_out = 0;
    end else begin
      m8_done = 0;
      if (m8_fl && cyc - m8_acc == 8) begin m8_done = 1; m8_out = m8_pend; end
      if (!m8_fl && start8) begin
        m8_fl = 1; m8_acc = cyc; m8_pend = expected_product(8, sm8, longint'(a8), longint'(b8));
      end else if (m8_fl && cyc - m8_acc == 9) m8_fl = 0;
      m8_busy = m8_fl;

      m16_done = 0;
      if (m16_fl && cyc - m16_acc == 16) begin m16_done = 1; m16_out = m16_pend; end
      if (!m16_fl && start16) begin
        m16_fl = 1; m16_acc = cyc; m16_pend = expected_product(16, sm16, longint'(a16), longint'(b16));
      end else if (m16_fl && cyc - m16_acc == 17) m16_fl = 0;
      m16_busy = m16_fl;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("busy8", longint'(busy8), longint'(m8_busy));
      checkOutput("done8", longint'(done8), longint'(m8_done));
      checkOutput("out8", longint'(out8), m8_out);
      checkOutput("busy16", longint'(busy16), longint'(m16_busy));
      checkOutput("done16", longint'(done16), longint'(m16_done));
      checkOutput("out16", longint'(out16), m16_out);
    end
  end

  task automatic runOp8(input bit sm, input logic [7:0] av, input logic [7:0] bv,
                        input longint want, input string name);
    int edges;
    bit seen;
    @(negedge clk);
    start8 = 1; sm8 = sm; a8 = av; b8 = bv;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
    seen = 0;
    while (!seen && edges < 40) begin
      if (done8) seen = 1;
      else begin @(posedge clk); edges++; @(negedge clk); end
    end
    checkOutput({name, "_seen"}, longint'(seen), 1);
    checkOutput({name, "_out"}, longint'(out8), want);
    checkOutput({name, "_lat"}, longint'(edges), 9);
  endtask

  task automatic runOp16(input bit sm, input logic [15:0] av, input logic [15:0] bv,
                         input longint want, input string name);
    int edges;
    bit seen;
    @(negedge clk);
    start16 = 1; sm16 = sm; a16 = av; b16 = bv;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start16 = 0; a16 = 16'($urandom); b16 = 16'($urandom);
    seen = 0;
    while (!seen && edges < 60) begin
      if (done16) seen = 1;
      else begin @(posedge clk); edges++; @(negedge clk); end
    end
    checkOutput({name, "_seen"}, longint'(seen), 1);
    checkOutput({name, "_out"}, longint'(out16), want);
    checkOutput({name, "_lat"}, longint'(edges), 17);
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n   = ($urandom % 150) != 0;
      start8  = ($urandom % 4) == 0;
      sm8     = 1'($urandom);
      a8      = 8'($urandom);
      b8      = 8'($urandom);
      start16 = ($urandom % 3) == 0;
      sm16    = 1'($urandom);
      a16     = 16'($urandom);
      b16     = 16'($urandom);
    end
    @(negedge clk);
    rst_n = 1; start8 = 0; start16 = 0;
  endtask

  initial begin
    int ndone, nd;
    int t[2];

    checkOutput("pin_unsigned", expected_product(8, 0, 'h25, 'h0F), 'h022B);
    checkOutput("pin_signed", expected_product(8, 1, 'hFD, 'h05), 'hFFF1);
    checkOutput("pin_minsq", expected_product(8, 1, 'h80, 'h80), 'h4000);

    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    checkOutput("rst_busy8", longint'(busy8), 0);
    checkOutput("rst_done8", longint'(done8), 0);
    checkOutput("rst_out8", longint'(out8), 0);
    checkOutput("rst_out16", longint'(out16), 0);
    rst_n = 1;

    runOp8(0, 8'h25, 8'h0F, 'h022B, "u25x0f");
    runOp8(0, 8'hFF, 8'hFF, 'hFE01, "uffxff");
    runOp8(1, 8'hFD, 8'h05, 'hFFF1, "sm3x5");
    runOp8(1, 8'h80, 8'h80, 'h4000, "sminxmin");
    runOp8(1, 8'h80, 8'h01, 'hFF80, "sminx1");
    runOp8(1, 8'h00, 8'h80, 'h0000, "negzero");
    runOp8(0, 8'h00, 8'h00, 'h0000, "zeros");

    @(negedge clk);
    start8 = 1; a8 = 3; b8 = 4; sm8 = 0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 20) start8 = 0;
      @(posedge clk);
      @(negedge clk);
      if (done8) begin
        if (ndone < 2) t[ndone] = cyc;
        ndone++;
        checkOutput("held_out", longint'(out8), 'h000C);
      end
    end
    checkOutput("held_count", longint'(ndone), 2);
    checkOutput("held_period", longint'(t[1] - t[0]), 10);

    @(negedge clk);
    start8 = 1; a8 = 5; b8 = 7; sm8 = 0;
    @(negedge clk);
    start8 = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    checkOutput("abort_busy", longint'(busy8), 0);
    checkOutput("abort_out", longint'(out8), 0);
    checkOutput("abort_done", longint'(done8), 0);
    rst_n = 1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) nd++;
    end
    checkOutput("abort_no_done", longint'(nd), 0);
    runOp8(0, 8'd2, 8'd3, 'h0006, "post_abort");

    runOp16(0, 16'hFFFF, 16'hFFFF, 'hFFFE0001, "w16_max");
    runOp16(1, 16'h8000, 16'h8000, 'h40000000, "w16_minsq");

    applyStimulus(900);
    repeat (25) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
